// File: rtl/i2c_slave_if.sv
// ---------------------------------------------------------------------------
// i2c_slave_if : I2C bus pins and register-write strobe bundle for i2c_slave
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface i2c_slave_if;
  logic       scl;
  logic       sda_in;
  logic       sda_oe;
  logic       wr_valid;
  logic [3:0] wr_index;
  logic [7:0] wr_data;
  logic       busy;

  modport slave (
    input  scl,
    input  sda_in,
    output sda_oe,
    output wr_valid,
    output wr_index,
    output wr_data,
    output busy
  );

  modport master (
    output scl,
    output sda_in,
    input  sda_oe,
    input  wr_valid,
    input  wr_index,
    input  wr_data,
    input  busy
  );
endinterface

`default_nettype wire

// File: rtl/i2c_slave.sv
// ---------------------------------------------------------------------------
// i2c_slave : 7-bit addressed I2C target with a 16 x 8 register file
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  i2c_slave_if.slave bus
);

  localparam logic [3:0] c_IDLE       = 4'd0;
  localparam logic [3:0] c_ADDR       = 4'd1;
  localparam logic [3:0] c_ADDR_ACK   = 4'd2;
  localparam logic [3:0] c_REG        = 4'd3;
  localparam logic [3:0] c_REG_ACK    = 4'd4;
  localparam logic [3:0] c_WDATA      = 4'd5;
  localparam logic [3:0] c_WDATA_ACK  = 4'd6;
  localparam logic [3:0] c_RDATA      = 4'd7;
  localparam logic [3:0] c_RDATA_ACK  = 4'd8;
  localparam logic [3:0] c_IGNORE     = 4'd9;

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_prev_q;
  logic                   sda_prev_q;

  logic       w_scl;
  logic       w_sda;
  logic       w_scl_rise;
  logic       w_scl_fall;
  logic       w_start;
  logic       w_stop;

  logic [3:0] state_q,    state_d;
  logic [3:0] bit_cnt_q,  bit_cnt_d;
  logic [7:0] shift_q,    shift_d;
  logic [7:0] tx_q,       tx_d;
  logic [3:0] ptr_q,      ptr_d;
  logic       rw_q,       rw_d;
  logic       mack_q,     mack_d;
  logic       sda_oe_q,   sda_oe_d;
  logic       busy_q,     busy_d;
  logic       wr_valid_q, wr_valid_d;
  logic [3:0] wr_index_q, wr_index_d;
  logic [7:0] wr_data_q,  wr_data_d;
  logic       w_rf_we;
  logic [7:0] rf_q [16];

  // Synchronisers idle high so a reset never fabricates a bus edge by itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], bus.scl};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], bus.sda_in};
      scl_prev_q <= scl_sync_q[SYNC_STAGES-1];
      sda_prev_q <= sda_sync_q[SYNC_STAGES-1];
    end
  end

  assign w_scl      = scl_sync_q[SYNC_STAGES-1];
  assign w_sda      = sda_sync_q[SYNC_STAGES-1];
  assign w_scl_rise = w_scl & ~scl_prev_q;
  assign w_scl_fall = ~w_scl & scl_prev_q;
  assign w_start    = w_scl & scl_prev_q & sda_prev_q & ~w_sda;
  assign w_stop     = w_scl & scl_prev_q & ~sda_prev_q & w_sda;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    ptr_d      = ptr_q;
    rw_d       = rw_q;
    mack_d     = mack_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    wr_valid_d = 1'b0;
    wr_index_d = wr_index_q;
    wr_data_d  = wr_data_q;
    w_rf_we    = 1'b0;

    if (w_stop) begin
      state_d   = c_IDLE;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      bit_cnt_d = 4'd0;
    end else if (w_start) begin
      state_d   = c_ADDR;
      sda_oe_d  = 1'b0;
      bit_cnt_d = 4'd0;
    end else begin
      case (state_q)
        c_ADDR, c_REG, c_WDATA: begin
          if (w_scl_rise && bit_cnt_q < 4'd8) begin
            shift_d   = {shift_q[6:0], w_sda};
            bit_cnt_d = bit_cnt_q + 4'd1;
            // Commit on the last data bit's rising edge; partial bytes never reach here.
            if (state_q == c_WDATA && bit_cnt_q == 4'd7) begin
              w_rf_we    = 1'b1;
              wr_valid_d = 1'b1;
              wr_index_d = ptr_q;
              wr_data_d  = {shift_q[6:0], w_sda};
              ptr_d      = ptr_q + 4'd1;
            end
          end else if (w_scl_fall && bit_cnt_q == 4'd8) begin
            bit_cnt_d = 4'd0;
            case (state_q)
              c_ADDR: begin
                if (shift_q[7:1] == SLAVE_ADDR) begin
                  state_d  = c_ADDR_ACK;
                  sda_oe_d = 1'b1;
                  busy_d   = 1'b1;
                  rw_d     = shift_q[0];
                end else begin
                  state_d  = c_IGNORE;
                end
              end
              c_REG: begin
                ptr_d    = shift_q[3:0];
                state_d  = c_REG_ACK;
                sda_oe_d = 1'b1;
              end
              default: begin
                state_d  = c_WDATA_ACK;
                sda_oe_d = 1'b1;
              end
            endcase
          end
        end

        c_ADDR_ACK: begin
          if (w_scl_fall) begin
            bit_cnt_d = 4'd0;
            if (rw_q) begin
              state_d  = c_RDATA;
              tx_d     = rf_q[ptr_q];
              sda_oe_d = ~rf_q[ptr_q][7];
            end else begin
              state_d  = c_REG;
              sda_oe_d = 1'b0;
            end
          end
        end

        c_REG_ACK, c_WDATA_ACK: begin
          if (w_scl_fall) begin
            state_d  = c_WDATA;
            sda_oe_d = 1'b0;
          end
        end

        c_RDATA: begin
          if (w_scl_rise && bit_cnt_q < 4'd8) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              ptr_d = ptr_q + 4'd1;
            end
          end else if (w_scl_fall && bit_cnt_q == 4'd8) begin
            state_d   = c_RDATA_ACK;
            sda_oe_d  = 1'b0;
            bit_cnt_d = 4'd0;
          end else if (w_scl_fall && bit_cnt_q != 4'd0) begin
            tx_d     = {tx_q[6:0], 1'b0};
            sda_oe_d = ~tx_q[6];
          end
        end

        c_RDATA_ACK: begin
          // bit_cnt doubles as a "master ACK bit sampled" marker here.
          if (w_scl_rise) begin
            mack_d    = ~w_sda;
            bit_cnt_d = 4'd1;
          end else if (w_scl_fall && bit_cnt_q == 4'd1) begin
            bit_cnt_d = 4'd0;
            if (mack_q) begin
              state_d  = c_RDATA;
              tx_d     = rf_q[ptr_q];
              sda_oe_d = ~rf_q[ptr_q][7];
            end else begin
              state_d  = c_IGNORE;
              sda_oe_d = 1'b0;
            end
          end
        end

        default: begin
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= c_IDLE;
      bit_cnt_q  <= 4'd0;
      shift_q    <= 8'h00;
      tx_q       <= 8'h00;
      ptr_q      <= 4'd0;
      rw_q       <= 1'b0;
      mack_q     <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_index_q <= 4'd0;
      wr_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      ptr_q      <= ptr_d;
      rw_q       <= rw_d;
      mack_q     <= mack_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      wr_valid_q <= wr_valid_d;
      wr_index_q <= wr_index_d;
      wr_data_q  <= wr_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        rf_q[i] <= 8'h00;
      end
    end else if (w_rf_we) begin
      rf_q[ptr_q] <= wr_data_d;
    end
  end

  assign bus.sda_oe   = sda_oe_q;
  assign bus.busy     = busy_q;
  assign bus.wr_valid = wr_valid_q;
  assign bus.wr_index = wr_index_q;
  assign bus.wr_data  = wr_data_q;

endmodule

`default_nettype wire

// File: tb/tb_i2c_slave.sv
// ---------------------------------------------------------------------------
// tb_i2c_slave : bit-banged I2C master, transaction-level model and scoreboard
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_i2c_slave;

  localparam int Q = 6;  // clk cycles per quarter scl period

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic scl_m = 1'b1;
  logic msda  = 1'b1;

  always #5 clk = ~clk;

  i2c_slave_if bus ();
  assign bus.scl    = scl_m;
  assign bus.sda_in = msda & ~bus.sda_oe;

  i2c_slave #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0]  mregs [16];
  logic [3:0]  mptr;
  logic [11:0] exp_wr [$];
  logic [7:0]  wbuf [16];
  logic        oe_seen = 1'b0;
  logic        wv_prev = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (bus.sda_oe) oe_seen = 1'b1;
    if (bus.wr_valid) begin
      if (wv_prev) chk("wr_pulse_width", 2, 1);
      else if (exp_wr.size() == 0) chk("wr_unexpected", {bus.wr_index, bus.wr_data}, 0);
      else chk("wr_event", {bus.wr_index, bus.wr_data}, exp_wr.pop_front());
    end
    wv_prev = bus.wr_valid;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic hq();
    repeat (Q) @(posedge clk);
  endtask

  task automatic i2c_start();
    msda = 1'b1; hq(); scl_m = 1'b1; hq(); msda = 1'b0; hq(); scl_m = 1'b0; hq();
  endtask

  task automatic i2c_stop();
    msda = 1'b0; hq(); scl_m = 1'b1; hq(); msda = 1'b1; hq(); hq();
  endtask

  task automatic put_bit(input logic b);
    msda = b; hq(); scl_m = 1'b1; hq(); hq(); scl_m = 1'b0; hq();
  endtask

  task automatic get_bit(output logic b);
    msda = 1'b1; hq(); scl_m = 1'b1; hq();
    @(negedge clk); b = bus.sda_in;
    hq(); scl_m = 1'b0; hq();
  endtask

  task automatic put_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    get_bit(b);
    ack = ~b;
  endtask

  task automatic get_byte(output logic [7:0] d, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      d[i] = b;
    end
    put_bit(~ack);
  endtask

  task automatic wr_txn(input logic [6:0] a, input logic [7:0] r, input int n, input logic do_stop);
    logic ack;
    logic match;
    match = (a == 7'h50);
    i2c_start();
    put_byte({a, 1'b0}, ack);
    chk("addr_ack", ack, match);
    @(negedge clk);
    chk("busy_after_addr", bus.busy, match);
    put_byte(r, ack);
    chk("reg_ack", ack, match);
    if (match) mptr = r[3:0];
    for (int i = 0; i < n; i++) begin
      if (match) begin
        exp_wr.push_back({mptr, wbuf[i]});
        mregs[mptr] = wbuf[i];
        mptr = mptr + 4'd1;
      end
      put_byte(wbuf[i], ack);
      chk("data_ack", ack, match);
    end
    if (do_stop) begin
      i2c_stop();
      @(negedge clk);
      chk("busy_after_stop", bus.busy, 0);
    end
  endtask

  task automatic rd_txn(input logic [6:0] a, input int n);
    logic       ack;
    logic [7:0] d;
    logic [7:0] exp;
    logic       match;
    match = (a == 7'h50);
    i2c_start();
    put_byte({a, 1'b1}, ack);
    chk("rd_addr_ack", ack, match);
    if (match) begin
      @(negedge clk);
      chk("rd_busy", bus.busy, 1);
      for (int i = 0; i < n; i++) begin
        exp  = mregs[mptr];
        mptr = mptr + 4'd1;
        get_byte(d, i != n - 1);
        chk("rd_data", d, exp);
      end
      @(negedge clk);
      chk("rd_release_after_nack", bus.sda_oe, 0);
    end
    i2c_stop();
    @(negedge clk);
    chk("rd_busy_after_stop", bus.busy, 0);
  endtask

  initial begin
    logic       b;
    logic       ack;
    logic [6:0] a;
    int         n;
    int         kind;

    for (int i = 0; i < 16; i++) mregs[i] = 8'h00;
    mptr = 4'd0;

    repeat (4) @(posedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_sda_oe", bus.sda_oe, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_wr_valid", bus.wr_valid, 0);
    chk("rst_wr_index", bus.wr_index, 0);
    chk("rst_wr_data", bus.wr_data, 0);
    hq();

    // Basic addressed write
    wbuf[0] = 8'hA5;
    wr_txn(7'h50, 8'h03, 1, 1'b1);

    // Foreign address: fully ignored
    oe_seen = 1'b0;
    wbuf[0] = 8'h12; wbuf[1] = 8'h34;
    wr_txn(7'h51, 8'h04, 2, 1'b1);
    chk("foreign_addr_oe_seen", oe_seen, 0);

    // Pointer wrap on write, then read reg 0 back
    wbuf[0] = 8'h11; wbuf[1] = 8'h22;
    wr_txn(7'h50, 8'h0F, 2, 1'b1);
    wr_txn(7'h50, 8'h00, 0, 1'b0);
    rd_txn(7'h50, 1);

    // Repeated START into a two-byte read from reg 2
    wbuf[0] = 8'h5C;
    wr_txn(7'h50, 8'h02, 1, 1'b1);
    wr_txn(7'h50, 8'h02, 0, 1'b0);
    rd_txn(7'h50, 2);

    // STOP after a half byte: nothing written
    i2c_start();
    put_byte({7'h50, 1'b0}, ack);
    put_byte(8'h05, ack);
    mptr = 4'd5;
    for (int i = 0; i < 4; i++) put_bit(1'b1);
    i2c_stop();
    @(negedge clk);
    chk("half_byte_busy", bus.busy, 0);
    rd_txn(7'h50, 1);

    // Reset pulse during the 5th data bit of a write
    i2c_start();
    put_byte({7'h50, 1'b0}, ack);
    put_byte(8'h07, ack);
    for (int i = 0; i < 4; i++) put_bit(1'b0);
    msda = 1'b1; hq();
    @(posedge clk); rst = 1'b1;
    @(posedge clk); rst = 1'b0;
    @(negedge clk);
    chk("midrst_sda_oe", bus.sda_oe, 0);
    chk("midrst_busy", bus.busy, 0);
    for (int i = 0; i < 16; i++) mregs[i] = 8'h00;
    mptr = 4'd0;
    scl_m = 1'b1; hq(); hq(); scl_m = 1'b0; hq();
    for (int i = 0; i < 3; i++) put_bit(1'b1);
    get_bit(b);
    chk("midrst_no_ack", b, 1);
    i2c_stop();
    wr_txn(7'h50, 8'h00, 0, 1'b0);
    rd_txn(7'h50, 16);

    // Randomized transactions against the model
    for (int t = 0; t < 12; t++) begin
      kind = $urandom_range(0, 2);
      a    = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'h50;
      n    = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
      case (kind)
        0: wr_txn(a, 8'($urandom), n, 1'b1);
        1: begin
          wr_txn(7'h50, 8'($urandom), 0, 1'b0);
          rd_txn(a, n);
        end
        default: rd_txn(a, n);
      endcase
    end

    repeat (8) @(posedge clk);
    chk("wr_queue_drained", exp_wr.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
